// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
// Stage entries carry a fixed-width register number field; modules use the
// low REG_AW bits and keep the rest zero.
package pipe_pkg;

    localparam int WNUM_MAX_W     = 8;
    localparam int DEF_ALU_STAGE  = 2;
    localparam int DEF_LOAD_STAGE = 4;

    typedef struct packed {
        logic                  valid;
        logic                  write;
        logic                  load;
        logic [WNUM_MAX_W-1:0] wnum;
    } stage_entry_t;

    localparam stage_entry_t BUBBLE = '0;

    // Builds a tracked entry from decoded issue fields
    function automatic stage_entry_t make_entry(input logic v, input logic w,
                                                input logic l,
                                                input logic [WNUM_MAX_W-1:0] n);
        stage_entry_t e;
        e.valid = v;
        e.write = w;
        e.load  = l;
        e.wnum  = n;
        return e;
    endfunction

endpackage

// File: rtl/pipe_fwd_sel.sv
// One source operand's producer search: scans S2..S(DEPTH) youngest first,
// takes the first valid writer of the requested register, and either forwards
// its stage result or requests a stall if that result is not yet available.
module pipe_fwd_sel
    import pipe_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int REG_AW     = 3,
    parameter int DEPTH      = 4,
    parameter int ALU_STAGE  = DEF_ALU_STAGE,
    parameter int LOAD_STAGE = DEF_LOAD_STAGE
) (
    input  stage_entry_t [DEPTH:1]    entries,
    input  logic [DEPTH*DATA_W-1:0]   stage_result,
    input  logic [REG_AW-1:0]         src_num,
    input  logic                      used,
    input  logic [DATA_W-1:0]         rf_data,
    output logic [DATA_W-1:0]         data,
    output logic                      need_stall
);

    logic found;

    // Loads deliver only at LOAD_STAGE; ALU results are available from ALU_STAGE on
    function automatic logic is_ready(input logic ld, input int k);
        return ld ? (k == LOAD_STAGE) : (k >= ALU_STAGE);
    endfunction

    // Priority search; the first match shadows any older writer of the same register
    always_comb begin
        data       = rf_data;
        need_stall = 1'b0;
        found      = 1'b0;
        for (int k = 2; k <= DEPTH; k++) begin
            if (used && !found && entries[k].valid && entries[k].write &&
                entries[k].wnum == WNUM_MAX_W'(src_num)) begin
                found = 1'b1;
                if (is_ready(entries[k].load, k))
                    data = stage_result[(k-1)*DATA_W +: DATA_W];
                else
                    need_stall = 1'b1;
            end
        end
    end

    // S1 entry, slice 0 of stage_result and spare wnum bits are not part of the search
    logic unused_ok;
    assign unused_ok = ^{entries, stage_result[DATA_W-1:0]};

endmodule

// File: rtl/pipe_hazard_fwd.sv
// Hazard and forwarding controller for the in-order pipeline.
// Tracks {valid, write, wnum, load} for S1..S(DEPTH), forwards operands to the
// S1 instruction, raises the load-use stall and applies branch flush to S1/S2.
// Optional: define PIPE_PERF_CNT_EN to add stall/flush event counters.
module pipe_hazard_fwd
    import pipe_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int REG_AW     = 3,
    parameter int NSRC       = 3,
    parameter int DEPTH      = 4,
    parameter int ALU_STAGE  = DEF_ALU_STAGE,
    parameter int LOAD_STAGE = DEF_LOAD_STAGE
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      issue_valid,
    input  logic                      issue_write,
    input  logic [REG_AW-1:0]         issue_wnum,
    input  logic                      issue_load,
    input  logic [NSRC-1:0]           s1_used,
    input  logic [NSRC*REG_AW-1:0]    s1_src_num,
    input  logic [NSRC*DATA_W-1:0]    rf_data,
    input  logic [DEPTH*DATA_W-1:0]   stage_result,
    input  logic                      flush,
    output logic [NSRC*DATA_W-1:0]    fwd_data,
    output logic                      stall,
`ifdef PIPE_PERF_CNT_EN
    output logic [31:0]               perf_stall_cnt,
    output logic [31:0]               perf_flush_cnt,
`endif
    output logic [DEPTH-1:0]          stg_write
);

    stage_entry_t [DEPTH:1] ent;
    stage_entry_t           issue_ent;
    logic [NSRC-1:0]        src_stall;

    assign issue_ent = make_entry(issue_valid, issue_write, issue_load,
                                  WNUM_MAX_W'(issue_wnum));

    // Stage-entry shift: stall holds S1 and bubbles S2, flush bubbles both and drops issue
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 1; k <= DEPTH; k++)
                ent[k] <= BUBBLE;
        end else begin
            if (flush) begin
                ent[1] <= BUBBLE;
                ent[2] <= BUBBLE;
            end else if (stall) begin
                ent[2] <= BUBBLE;
            end else begin
                ent[1] <= issue_ent;
                ent[2] <= ent[1];
            end
            for (int k = 3; k <= DEPTH; k++)
                ent[k] <= ent[k-1];
        end
    end

    // One priority search per source operand of the S1 instruction
    for (genvar s = 0; s < NSRC; s++) begin : g_src
        pipe_fwd_sel #(
            .DATA_W    (DATA_W),
            .REG_AW    (REG_AW),
            .DEPTH     (DEPTH),
            .ALU_STAGE (ALU_STAGE),
            .LOAD_STAGE(LOAD_STAGE)
        ) u_sel (
            .entries     (ent),
            .stage_result(stage_result),
            .src_num     (s1_src_num[s*REG_AW +: REG_AW]),
            .used        (ent[1].valid & s1_used[s]),
            .rf_data     (rf_data[s*DATA_W +: DATA_W]),
            .data        (fwd_data[s*DATA_W +: DATA_W]),
            .need_stall  (src_stall[s])
        );
    end

    // A flush squashes the stalled instruction, so it also cancels the stall
    always_comb begin
        stall = (|src_stall) & ~flush;
    end

    // Per-stage write-enable view for trace
    always_comb begin
        stg_write = '0;
        for (int k = 1; k <= DEPTH; k++)
            stg_write[k-1] = ent[k].valid & ent[k].write;
    end

`ifdef PIPE_PERF_CNT_EN
    // Free-running event counters, wrapping at 2**32
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (stall)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (flush)
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_fwd.sv
// Self-checking bench for pipe_hazard_fwd: reset check, a directed table of
// multi-cycle hazard sequences, then randomized traffic against a reference model.
module tb_pipe_hazard_fwd;

    localparam int DATA_W     = 16;
    localparam int REG_AW     = 3;
    localparam int NSRC       = 3;
    localparam int DEPTH      = 4;
    localparam int ALU_STAGE  = 2;
    localparam int LOAD_STAGE = 4;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      issue_valid, issue_write, issue_load;
    logic [REG_AW-1:0]         issue_wnum;
    logic [NSRC-1:0]           s1_used;
    logic [NSRC*REG_AW-1:0]    s1_src_num;
    logic [NSRC*DATA_W-1:0]    rf_data;
    logic [DEPTH*DATA_W-1:0]   stage_result;
    logic                      flush;
    logic [NSRC*DATA_W-1:0]    fwd_data;
    logic                      stall;
    logic [DEPTH-1:0]          stg_write;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0]               perf_stall_cnt, perf_flush_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipe_hazard_fwd #(
        .DATA_W(DATA_W), .REG_AW(REG_AW), .NSRC(NSRC), .DEPTH(DEPTH),
        .ALU_STAGE(ALU_STAGE), .LOAD_STAGE(LOAD_STAGE)
    ) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_write(issue_write),
        .issue_wnum(issue_wnum), .issue_load(issue_load),
        .s1_used(s1_used), .s1_src_num(s1_src_num), .rf_data(rf_data),
        .stage_result(stage_result), .flush(flush),
        .fwd_data(fwd_data), .stall(stall),
`ifdef PIPE_PERF_CNT_EN
        .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt),
`endif
        .stg_write(stg_write)
    );

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic check_fwd(input string nm, input logic [NSRC-1:0] mask,
                             input logic [NSRC*DATA_W-1:0] exp);
        for (int s = 0; s < NSRC; s++)
            if (mask[s])
                check($sformatf("%s fwd%0d", nm, s),
                      64'(fwd_data[s*DATA_W +: DATA_W]), 64'(exp[s*DATA_W +: DATA_W]));
    endtask

    task automatic randomize_inputs();
        issue_valid = 1'($urandom);
        issue_write = 1'($urandom);
        issue_load  = ($urandom_range(0, 2) == 0);
        issue_wnum  = REG_AW'($urandom_range(0, 3));
        s1_used     = NSRC'($urandom);
        for (int s = 0; s < NSRC; s++) begin
            s1_src_num[s*REG_AW +: REG_AW] = REG_AW'($urandom_range(0, 3));
            rf_data[s*DATA_W +: DATA_W]    = DATA_W'($urandom);
        end
        for (int k = 0; k < DEPTH; k++)
            stage_result[k*DATA_W +: DATA_W] = DATA_W'($urandom);
        flush = ($urandom_range(0, 9) == 0);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        iv, iw, ild;
        logic [2:0]  wn;
        logic [2:0]  used;
        logic [2:0]  s0, s1, s2;
        logic        fl;
        logic [15:0] r2, r3, r4;
        logic        es;
        logic [3:0]  eg;
        logic [2:0]  fchk;
        logic [15:0] f0, f1, f2;
    } vec_t;

    vec_t tbl[16];

    // ---------------- reference model ----------------
    // In-flight instruction record for stage k (index = stage number)
    typedef struct { bit v; bit w; bit l; int n; } ment_t;
    ment_t m[1:DEPTH];
    int    pc_stall, pc_flush;

    function automatic bit result_available(input bit is_load, input int stage);
        if (is_load) return stage == LOAD_STAGE;
        return stage >= ALU_STAGE;
    endfunction

    task automatic model_eval(output logic [NSRC*DATA_W-1:0] ef,
                              output logic [NSRC-1:0] chk, output bit es,
                              output logic [DEPTH-1:0] eg);
        int k;
        es  = 0;
        ef  = rf_data;
        chk = '1;
        for (int s = 0; s < NSRC; s++) begin
            if (m[1].v && s1_used[s]) begin
                k = 2;
                while (k <= DEPTH &&
                       !(m[k].v && m[k].w && m[k].n == int'(s1_src_num[s*REG_AW +: REG_AW])))
                    k++;
                if (k <= DEPTH) begin
                    if (result_available(m[k].l, k))
                        ef[s*DATA_W +: DATA_W] = stage_result[(k-1)*DATA_W +: DATA_W];
                    else begin
                        es     = 1;
                        chk[s] = 1'b0;
                    end
                end
            end
        end
        if (flush) es = 0;
        for (int j = 1; j <= DEPTH; j++)
            eg[j-1] = m[j].v & m[j].w;
    endtask

    task automatic model_step(input bit es);
        if (rst) begin
            for (int j = 1; j <= DEPTH; j++) m[j] = '{0, 0, 0, 0};
            pc_stall = 0;
            pc_flush = 0;
        end else begin
            for (int j = DEPTH; j >= 3; j--) m[j] = m[j-1];
            if (flush) begin
                m[2] = '{0, 0, 0, 0};
                m[1] = '{0, 0, 0, 0};
            end else if (es) begin
                m[2] = '{0, 0, 0, 0};
            end else begin
                m[2] = m[1];
                m[1] = '{issue_valid, issue_write, issue_load, int'(issue_wnum)};
            end
            pc_stall += int'(es);
            pc_flush += int'(flush);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [NSRC*DATA_W-1:0] ef;
        logic [NSRC-1:0]        chk;
        logic [DEPTH-1:0]       eg;
        bit                     es;

        //      iv iw ld wn used s0 s1 s2 fl r2        r3        r4        es eg       fchk    f0        f1        f2
        tbl[0]  = '{1, 1, 0, 3, 3'b000, 0, 0, 0, 0, 16'h2222, 16'h3333, 16'h4444, 0, 4'b0000, 3'b111, 16'hA000, 16'hA001, 16'hA002};
        tbl[1]  = '{1, 0, 0, 0, 3'b000, 0, 0, 0, 0, 16'h2222, 16'h3333, 16'h4444, 0, 4'b0001, 3'b111, 16'hA000, 16'hA001, 16'hA002};
        tbl[2]  = '{0, 0, 0, 0, 3'b001, 3, 0, 0, 0, 16'h1234, 16'h3333, 16'h4444, 0, 4'b0010, 3'b111, 16'h1234, 16'hA001, 16'hA002};
        tbl[3]  = '{1, 1, 1, 2, 3'b001, 3, 0, 0, 0, 16'h1234, 16'h3333, 16'h4444, 0, 4'b0100, 3'b111, 16'hA000, 16'hA001, 16'hA002};
        tbl[4]  = '{1, 0, 0, 0, 3'b000, 0, 0, 0, 0, 16'h2222, 16'h3333, 16'h4444, 0, 4'b1001, 3'b111, 16'hA000, 16'hA001, 16'hA002};
        tbl[5]  = '{1, 1, 0, 6, 3'b010, 0, 2, 0, 0, 16'h2222, 16'h3333, 16'h4444, 1, 4'b0010, 3'b101, 16'hA000, 16'h0000, 16'hA002};
        tbl[6]  = '{1, 1, 0, 6, 3'b010, 0, 2, 0, 0, 16'h2222, 16'h3333, 16'h4444, 1, 4'b0100, 3'b101, 16'hA000, 16'h0000, 16'hA002};
        tbl[7]  = '{1, 1, 0, 5, 3'b010, 0, 2, 0, 0, 16'h2222, 16'h3333, 16'hBEEF, 0, 4'b1000, 3'b111, 16'hA000, 16'hBEEF, 16'hA002};
        tbl[8]  = '{1, 1, 0, 5, 3'b000, 0, 0, 0, 0, 16'h2222, 16'h3333, 16'h4444, 0, 4'b0001, 3'b111, 16'hA000, 16'hA001, 16'hA002};
        tbl[9]  = '{0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 16'h2222, 16'h3333, 16'h4444, 0, 4'b0011, 3'b111, 16'hA000, 16'hA001, 16'hA002};
        tbl[10] = '{1, 0, 0, 0, 3'b000, 0, 0, 0, 0, 16'h2222, 16'h3333, 16'h4444, 0, 4'b0110, 3'b111, 16'hA000, 16'hA001, 16'hA002};
        tbl[11] = '{1, 1, 1, 1, 3'b100, 0, 0, 5, 0, 16'h7777, 16'h0002, 16'h0001, 0, 4'b1100, 3'b111, 16'hA000, 16'hA001, 16'h0002};
        tbl[12] = '{1, 0, 0, 0, 3'b000, 0, 0, 0, 0, 16'h2222, 16'h3333, 16'h4444, 0, 4'b1001, 3'b111, 16'hA000, 16'hA001, 16'hA002};
        tbl[13] = '{1, 1, 0, 7, 3'b001, 1, 0, 0, 0, 16'h2222, 16'h3333, 16'h4444, 1, 4'b0010, 3'b110, 16'h0000, 16'hA001, 16'hA002};
        tbl[14] = '{1, 1, 0, 7, 3'b001, 1, 0, 0, 1, 16'h2222, 16'h3333, 16'h4444, 0, 4'b0100, 3'b110, 16'h0000, 16'hA001, 16'hA002};
        tbl[15] = '{0, 0, 0, 0, 3'b001, 1, 0, 0, 0, 16'h2222, 16'h3333, 16'h4444, 0, 4'b1000, 3'b111, 16'hA000, 16'hA001, 16'hA002};

        // Reset held two cycles with random inputs
        rst = 1'b1;
        randomize_inputs();
        @(posedge clk); #1;
        randomize_inputs();
        @(posedge clk); #1;
        rst = 1'b0;
        randomize_inputs();
        flush = 1'b0;
        #4;
        check("reset stall", 64'(stall), 64'd0);
        check("reset stg_write", 64'(stg_write), 64'd0);
        check_fwd("reset", '1, rf_data);
`ifdef PIPE_PERF_CNT_EN
        check("reset perf_stall_cnt", 64'(perf_stall_cnt), 64'd0);
        check("reset perf_flush_cnt", 64'(perf_flush_cnt), 64'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed sequences: ALU back-to-back, load-use, priority, flush during stall
        for (int i = 0; i < 16; i++) begin
            issue_valid  = tbl[i].iv;
            issue_write  = tbl[i].iw;
            issue_load   = tbl[i].ild;
            issue_wnum   = tbl[i].wn;
            s1_used      = tbl[i].used;
            s1_src_num   = {tbl[i].s2, tbl[i].s1, tbl[i].s0};
            rf_data      = {16'hA002, 16'hA001, 16'hA000};
            stage_result = {tbl[i].r4, tbl[i].r3, tbl[i].r2, 16'hDEAD};
            flush        = tbl[i].fl;
            #4;
            check($sformatf("row%0d stall", i), 64'(stall), 64'(tbl[i].es));
            check($sformatf("row%0d stg_write", i), 64'(stg_write), 64'(tbl[i].eg));
            check_fwd($sformatf("row%0d", i), tbl[i].fchk, {tbl[i].f2, tbl[i].f1, tbl[i].f0});
            @(posedge clk); #1;
        end
`ifdef PIPE_PERF_CNT_EN
        check("table perf_stall_cnt", 64'(perf_stall_cnt), 64'd3);
        check("table perf_flush_cnt", 64'(perf_flush_cnt), 64'd1);
`endif

        // Randomized traffic against the reference model
        for (int c = 0; c < 2000; c++) begin
            randomize_inputs();
            rst = (c == 0) || ($urandom_range(0, 59) == 0);
            #4;
            model_eval(ef, chk, es, eg);
            check($sformatf("rnd%0d stall", c), 64'(stall), 64'(es));
            check($sformatf("rnd%0d stg_write", c), 64'(stg_write), 64'(eg));
            check_fwd($sformatf("rnd%0d", c), chk, ef);
`ifdef PIPE_PERF_CNT_EN
            if (c > 0) begin
                check($sformatf("rnd%0d perf_stall_cnt", c), 64'(perf_stall_cnt), 64'(pc_stall));
                check($sformatf("rnd%0d perf_flush_cnt", c), 64'(perf_flush_cnt), 64'(pc_flush));
            end
`endif
            model_step(es);
            @(posedge clk); #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
